uart_fifo_ctrl: RTL and testbench

//  Memory-mapped UART peripheral with parametrised TX/RX FIFOs, runtime baud divisor, optional parity
//  and 1/2 stop bits, sticky error flags and a level interrupt. Sits on the core's peripheral bus
//  (configure/read strobes, byte address, 32-bit data). Serialiser/deserialiser are internal.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo_ctrl_if.sv | 11 +
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_fifo_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART peripheral: register map, CTRL/STAT bit positions and FSM states.
package uart_pkg;
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STAT   = 8'h04;
    localparam logic [7:0] ADDR_DIV    = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h0c;
    localparam logic [7:0] ADDR_RXDATA = 8'h10;
    localparam logic [7:0] ADDR_LEVEL  = 8'h14;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_RX_EN   = 1;
    localparam int CTRL_PAR_EN  = 2;
    localparam int CTRL_PAR_ODD = 3;
    localparam int CTRL_STOP2   = 4;
    localparam int CTRL_IRQ_RX  = 5;
    localparam int CTRL_IRQ_TXE = 6;

    localparam int STAT_TX_BUSY   = 0;
    localparam int STAT_RX_NEMPTY = 1;
    localparam int STAT_TX_FULL   = 2;
    localparam int STAT_RX_OVR    = 3;
    localparam int STAT_PAR_ERR   = 4;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_TX_OVF    = 6;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Peripheral bus between the core and the UART: strobes, byte address, 32-bit write/read data.
interface uart_fifo_ctrl_if;
    logic        configure;
    logic        read;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output configure, read, addr, data_in, input data_out);
    modport slave  (input configure, read, addr, data_in, output data_out);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q;
    logic [CW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART: registered bus stage, CTRL/STAT/DIV registers, TX/RX FIFOs and bit-level FSMs.
//  state  | meaning
//  IDLE   | line idle (TX holds 1; RX waits for a falling edge)
//  START  | start bit (RX re-checks it at half a bit to reject glitches)
//  DATA   | 8 data bits, LSB first
//  PARITY | optional parity bit
//  STOP   | stop bit(s); TX chains straight into the next START when more data is queued
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter int          DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic             clk,
    input  logic             rst,
    uart_fifo_ctrl_if.slave  bus,
    output logic             irq_o,
    output logic             tx_o,
    input  logic             rx_i
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic                 cfg_q, rd_q;
    logic [7:0]           addr_q;
    logic [31:0]          wdata_q;
    logic [6:0]           ctrl_q;
    logic [DIV_WIDTH-1:0] div_q, div_eff;
    logic                 rx_overrun_q, par_err_q, frame_err_q, tx_overflow_q, irq_q;
    logic [3:0]           w1c;
    logic [6:0]           stat;
    logic                 unused_bits;

    logic                 tx_push, tx_pop, tx_full, tx_empty, tx_busy;
    logic [7:0]           tx_dout;
    logic [TCW-1:0]       tx_count;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]           rx_dout;
    logic [RCW-1:0]       rx_count;

    tx_state_e            tx_state_q;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_div_q;
    logic [2:0]           tx_bit_q;
    logic [7:0]           tx_shift_q;
    logic                 tx_par_q, tx_par_en_q, tx_stop2_q, tx_stop_left_q, tx_q;
    logic                 tx_tc, tx_frame_end;

    rx_state_e            rx_state_q;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_div_q;
    logic [2:0]           rx_bit_q;
    logic [7:0]           rx_shift_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_par_en_q, rx_par_odd_q, rx_par_bad_q, rx_tc;

    assign unused_bits = ^{bus.addr[31:8], wdata_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cfg_q   <= bus.configure;
            rd_q    <= bus.read;
            addr_q  <= bus.addr[7:0];
            wdata_q <= bus.data_in;
        end
    end

    assign tx_push = cfg_q && (addr_q == ADDR_TXDATA);
    assign rx_pop  = rd_q && (addr_q == ADDR_RXDATA);
    assign w1c     = (cfg_q && addr_q == ADDR_STAT) ? wdata_q[6:3] : 4'b0;
    assign div_eff = (div_q < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_q;
    assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;
    assign stat    = {tx_overflow_q, frame_err_q, par_err_q, rx_overrun_q, tx_full, !rx_empty, tx_busy};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q        <= '0;
            div_q         <= DIV_WIDTH'(DEFAULT_DIV);
            rx_overrun_q  <= 1'b0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_overflow_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            if (cfg_q && addr_q == ADDR_CTRL) ctrl_q <= wdata_q[6:0];
            if (cfg_q && addr_q == ADDR_DIV)  div_q  <= wdata_q[DIV_WIDTH-1:0];
            // hardware set wins over a same-cycle write-1-to-clear
            rx_overrun_q  <= (rx_overrun_q  && !w1c[0]) || (rx_push && rx_full && !rx_pop);
            par_err_q     <= (par_err_q     && !w1c[1]) || (rx_push && rx_par_bad_q);
            frame_err_q   <= (frame_err_q   && !w1c[2]) || (rx_push && !rx_s2_q);
            tx_overflow_q <= (tx_overflow_q && !w1c[3]) || (tx_push && tx_full && !tx_pop);
            irq_q <= (ctrl_q[CTRL_IRQ_RX] && !rx_empty) || (ctrl_q[CTRL_IRQ_TXE] && !tx_busy)
                     || (|stat[STAT_TX_OVF:STAT_RX_OVR]);
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (addr_q)
            ADDR_CTRL:   bus.data_out = {25'b0, ctrl_q};
            ADDR_STAT:   bus.data_out = {25'b0, stat};
            ADDR_DIV:    bus.data_out = 32'(div_q);
            ADDR_RXDATA: if (!rx_empty) bus.data_out = {24'b0, rx_dout};
            ADDR_LEVEL:  bus.data_out = {16'(rx_count), 16'(tx_count)};
            default:     bus.data_out = '0;
        endcase
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(wdata_q[7:0]),
        .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_shift_q),
        .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    assign tx_tc        = (tx_cnt_q == '0);
    assign tx_frame_end = (tx_state_q == TX_STOP) && tx_tc && !tx_stop_left_q;
    assign tx_pop       = ctrl_q[CTRL_TX_EN] && !tx_empty && ((tx_state_q == TX_IDLE) || tx_frame_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q     <= TX_IDLE;
            tx_cnt_q       <= '0;
            tx_div_q       <= '0;
            tx_bit_q       <= '0;
            tx_shift_q     <= '0;
            tx_par_q       <= 1'b0;
            tx_par_en_q    <= 1'b0;
            tx_stop2_q     <= 1'b0;
            tx_stop_left_q <= 1'b0;
            tx_q           <= 1'b1;
        end else if (tx_pop) begin
            tx_state_q  <= TX_START;
            tx_q        <= 1'b0;
            tx_cnt_q    <= div_eff - ONE;
            tx_div_q    <= div_eff;
            tx_shift_q  <= tx_dout;
            tx_par_q    <= (^tx_dout) ^ ctrl_q[CTRL_PAR_ODD];
            tx_par_en_q <= ctrl_q[CTRL_PAR_EN];
            tx_stop2_q  <= ctrl_q[CTRL_STOP2];
        end else if (!tx_tc) begin
            tx_cnt_q <= tx_cnt_q - ONE;
        end else begin
            tx_cnt_q <= tx_div_q - ONE;
            case (tx_state_q)
                TX_START: begin
                    tx_state_q <= TX_DATA;
                    tx_q       <= tx_shift_q[0];
                    tx_bit_q   <= 3'd7;
                end
                TX_DATA: begin
                    if (tx_bit_q == 3'd0) begin
                        tx_state_q     <= tx_par_en_q ? TX_PARITY : TX_STOP;
                        tx_q           <= tx_par_en_q ? tx_par_q : 1'b1;
                        tx_stop_left_q <= tx_stop2_q;
                    end else begin
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_q       <= tx_shift_q[1];
                        tx_bit_q   <= tx_bit_q - 3'd1;
                    end
                end
                TX_PARITY: begin
                    tx_state_q     <= TX_STOP;
                    tx_q           <= 1'b1;
                    tx_stop_left_q <= tx_stop2_q;
                end
                TX_STOP: begin
                    if (tx_stop_left_q) begin
                        tx_stop_left_q <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                        tx_cnt_q   <= '0;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_q       <= 1'b1;
                    tx_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_tc   = (rx_cnt_q == '0);
    assign rx_push = (rx_state_q == RX_STOP) && rx_tc && ctrl_q[CTRL_RX_EN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_div_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (!ctrl_q[CTRL_RX_EN]) begin
                rx_state_q <= RX_IDLE;
                rx_cnt_q   <= '0;
            end else if (rx_state_q == RX_IDLE) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q   <= RX_START;
                    rx_cnt_q     <= (div_eff >> 1) - ONE;
                    rx_div_q     <= div_eff;
                    rx_par_en_q  <= ctrl_q[CTRL_PAR_EN];
                    rx_par_odd_q <= ctrl_q[CTRL_PAR_ODD];
                    rx_par_bad_q <= 1'b0;
                end
            end else if (!rx_tc) begin
                rx_cnt_q <= rx_cnt_q - ONE;
            end else begin
                rx_cnt_q <= rx_div_q - ONE;
                case (rx_state_q)
                    RX_START: begin
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                            rx_cnt_q   <= '0;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= 3'd7;
                        end
                    end
                    RX_DATA: begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd0) rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q - 3'd1;
                    end
                    RX_PARITY: begin
                        rx_par_bad_q <= rx_s2_q != ((^rx_shift_q) ^ rx_par_odd_q);
                        rx_state_q   <= RX_STOP;
                    end
                    default: begin
                        rx_state_q <= RX_IDLE;
                        rx_cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: bus tasks, serial driver/monitor and a queue-based reference.
module tb_uart_fifo_ctrl;
    import uart_pkg::*;

    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic irq, tx;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    uart_fifo_ctrl_if bus();

    uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_WIDTH(16), .DEFAULT_DIV(434)) dut (
        .clk(clk), .rst(rst), .bus(bus), .irq_o(irq), .tx_o(tx), .rx_i(rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.configure = 1'b1;
        bus.addr      = {24'b0, a};
        bus.data_in   = d;
        @(negedge clk);
        bus.configure = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.read = 1'b1;
        bus.addr = {24'b0, a};
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.data_out;
        @(negedge clk);
    endtask

    task automatic rx_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit has_par, input bit par, input bit stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (has_par) rx_bit(par);
        rx_bit(stop);
        rx_bit(1'b1);
    endtask

    // Samples nbits of a frame at mid-bit, starting from the first low sample on tx.
    task automatic capture_frame(input int nbits, output logic [15:0] bits, output int start_cyc, output bit ok);
        ok = 1'b0;
        bits = '0;
        start_cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            start_cyc = cyc;
            repeat (DIV / 2) @(posedge clk);
            #1 bits[0] = tx;
            for (int i = 1; i < nbits; i++) begin
                repeat (DIV) @(posedge clk);
                #1 bits[i] = tx;
            end
        end
    endtask

    function automatic logic [15:0] model_frame(input logic [7:0] b, input bit pe, input bit po,
                                                input bit s2, output int n);
        logic [15:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        n = 9;
        if (pe) begin
            f[n] = ((ones % 2) == 1) ^ po;
            n++;
        end
        f[n] = 1'b1;
        n++;
        if (s2) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    task automatic wait_tx_idle(input int budget, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(ADDR_STAT, d);
            if (d[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(ADDR_CTRL, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_stat: got %h expected 0", d); end
        bus_read(ADDR_DIV, d);
        n_tests++;
        if (d !== 32'd434) begin n_fail++; $display("FAIL reset_div: got %0d expected 434", d); end
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h expected 0", d); end
        bus_read(8'h20, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
    endtask

    task automatic test_tx_basic();
        logic [15:0] f1, f2, e;
        int s1, s2, n;
        bit ok1, ok2, idle;
        logic [31:0] d;
        bus_write(ADDR_DIV, DIV);
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_TXDATA, 32'h55);
        bus_write(ADDR_TXDATA, 32'hA3);
        bus_write(ADDR_CTRL, 32'h1);
        capture_frame(10, f1, s1, ok1);
        capture_frame(10, f2, s2, ok2);
        e = model_frame(8'h55, 1'b0, 1'b0, 1'b0, n);
        n_tests++;
        if (!ok1 || f1 !== e) begin n_fail++; $display("FAIL tx_frame_55: got %h expected %h", f1, e); end
        e = model_frame(8'hA3, 1'b0, 1'b0, 1'b0, n);
        n_tests++;
        if (!ok2 || f2 !== e) begin n_fail++; $display("FAIL tx_frame_a3: got %h expected %h", f2, e); end
        n_tests++;
        if (s2 - s1 != 10 * DIV) begin n_fail++; $display("FAIL tx_back_to_back: got %0d expected %0d", s2 - s1, 10 * DIV); end
        wait_tx_idle(200, idle);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (!idle || d[0] !== 1'b0) begin n_fail++; $display("FAIL tx_busy_clear: got %b expected 0", d[0]); end
    endtask

    task automatic test_tx_random();
        logic [7:0] b;
        logic [15:0] got, e;
        bit pe, po, s2, ok, idle;
        int n, sc;
        logic [31:0] cv;
        for (int it = 0; it < 4; it++) begin
            b  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            cv = {27'b0, s2, po, pe, 2'b00};
            bus_write(ADDR_CTRL, cv);
            bus_write(ADDR_TXDATA, {24'b0, b});
            bus_write(ADDR_CTRL, cv | 32'h1);
            e = model_frame(b, pe, po, s2, n);
            capture_frame(n, got, sc, ok);
            n_tests++;
            if (!ok || got !== e) begin
                n_fail++;
                $display("FAIL tx_random_frame: byte %h pe %b po %b s2 %b got %h expected %h", b, pe, po, s2, got, e);
            end
            wait_tx_idle(200, idle);
            n_tests++;
            if (!idle) begin n_fail++; $display("FAIL tx_random_idle: got busy expected idle"); end
        end
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        bit idle;
        bus_write(ADDR_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) bus_write(ADDR_TXDATA, 32'(i));
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (d[15:0] !== 16'd16) begin n_fail++; $display("FAIL ovf_level: got %0d expected 16", d[15:0]); end
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_tx_full: got %b expected 1", d[2]); end
        n_tests++;
        if (d[6] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", d[6]); end
        bus_write(ADDR_STAT, 32'h40);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[6] !== 1'b0 || d[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_w1c: got %h expected bit6=0 bit2=1", d); end
        bus_write(ADDR_CTRL, 32'h1);
        wait_tx_idle(1000, idle);
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (!idle || d[15:0] !== 16'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d expected 0", d[15:0]); end
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_rx_parity();
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0E);
        send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[4] !== 1'b0) begin n_fail++; $display("FAIL rx_par_ok_flag: got %b expected 0", d[4]); end
        bus_read(ADDR_RXDATA, d);
        n_tests++;
        if (d !== 32'h3C) begin n_fail++; $display("FAIL rx_par_ok_data: got %h expected 3c", d); end
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[4] !== 1'b1) begin n_fail++; $display("FAIL rx_par_bad_flag: got %b expected 1", d[4]); end
        bus_read(ADDR_RXDATA, d);
        n_tests++;
        if (d !== 32'h3C) begin n_fail++; $display("FAIL rx_par_bad_data: got %h expected 3c", d); end
        bus_write(ADDR_STAT, 32'h10);
    endtask

    task automatic test_rx_overrun();
        logic [7:0]  exp_q[$];
        logic [7:0]  b, e;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h22);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            send_rx(b, 1'b0, 1'b0, 1'b1);
            if (exp_q.size() < 16) exp_q.push_back(b);
        end
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (d[31:16] !== 16'd16) begin n_fail++; $display("FAIL rx_ovr_level: got %0d expected 16", d[31:16]); end
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[3] !== 1'b1) begin n_fail++; $display("FAIL rx_ovr_flag: got %b expected 1", d[3]); end
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_ovr_irq: got %b expected 1", irq); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            bus_read(ADDR_RXDATA, d);
            n_tests++;
            if (d !== {24'b0, e}) begin n_fail++; $display("FAIL rx_drain_%0d: got %h expected %h", i, d, e); end
        end
        bus_read(ADDR_RXDATA, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h expected 0", d); end
        bus_write(ADDR_STAT, 32'h78);
        repeat (2) @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_rx_glitch_frame();
        logic [31:0] d;
        logic [7:0]  b;
        bus_write(ADDR_CTRL, 32'h02);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (d[31:16] !== 16'd0) begin n_fail++; $display("FAIL rx_glitch_level: got %0d expected 0", d[31:16]); end
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b0, 1'b0, 1'b0);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d[5] !== 1'b1) begin n_fail++; $display("FAIL rx_frame_err: got %b expected 1", d[5]); end
        bus_read(ADDR_RXDATA, d);
        n_tests++;
        if (d !== {24'b0, b}) begin n_fail++; $display("FAIL rx_frame_err_data: got %h expected %h", d, b); end
        bus_write(ADDR_STAT, 32'h20);
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_TXDATA, 32'h00);
        bus_write(ADDR_TXDATA, 32'h00);
        repeat (30) @(negedge clk);
        n_tests++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_tx: got %b expected 0", tx); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx_immediate: got %b expected 1", tx); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_stat: got %h expected 0", d); end
        bus_read(ADDR_LEVEL, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_level: got %h expected 0", d); end
        bus_read(ADDR_DIV, d);
        n_tests++;
        if (d !== 32'd434) begin n_fail++; $display("FAIL rst_div: got %0d expected 434", d); end
    endtask

    initial begin
        bus.configure = 1'b0;
        bus.read      = 1'b0;
        bus.addr      = '0;
        bus.data_in   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_tx_overflow();
        test_rx_parity();
        test_rx_overrun();
        test_rx_glitch_frame();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
